// File: rtl/univ_reg.sv
// univ_reg: universal load/shift/rotate register with carry, complement and zero flags.
// Define UNIV_REG_COUNT_EN to build INC/DEC; otherwise modes 110/111 hold.
module univ_reg #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             en_in,
  input  logic [2:0]       mode_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] q_comp,
  output logic             carry_out,
  output logic             zero_out
);
  logic [WIDTH-1:0] q, q_nxt;
  logic c, c_nxt;
  always_comb begin
    q_nxt = q;
    c_nxt = c;
    case (mode_in)
      3'b001: begin q_nxt = d_in;                     c_nxt = 1'b0;       end
      3'b010: begin q_nxt = {q[WIDTH-2:0], ser_in};   c_nxt = q[WIDTH-1]; end
      3'b011: begin q_nxt = {ser_in, q[WIDTH-1:1]};   c_nxt = q[0];       end
      3'b100: begin q_nxt = {q[WIDTH-2:0], q[WIDTH-1]}; c_nxt = q[WIDTH-1]; end
      3'b101: begin q_nxt = {q[0], q[WIDTH-1:1]};     c_nxt = q[0];       end
`ifdef UNIV_REG_COUNT_EN
      3'b110: begin q_nxt = q + WIDTH'(1);            c_nxt = &q;         end
      3'b111: begin q_nxt = q - WIDTH'(1);            c_nxt = ~|q;        end
`endif
      default: ;
    endcase
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      q <= RESET_VAL;
      c <= 1'b0;
    end else if (en_in) begin
      q <= q_nxt;
      c <= c_nxt;
    end
  assign q_out     = q;
  assign q_comp    = ~q;
  assign carry_out = c;
  assign zero_out  = (q == '0);
endmodule

// File: tb/tb_univ_reg.sv
// tb_univ_reg: randomized and directed checks of univ_reg against an arithmetic reference model.
module tb_univ_reg;
`ifdef UNIV_REG_COUNT_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, en, ser, en2, ser2;
  logic [2:0] mode, mode2;
  logic [7:0] d, q, qc;
  logic [15:0] d2, q2, qc2;
  logic c, z, c2, z2;
  int checks = 0, errors = 0;
  int mq = 0, mc = 0;

  univ_reg dut (.clk_in(clk), .rst_n_in(rst_n), .en_in(en), .mode_in(mode), .d_in(d),
                .ser_in(ser), .q_out(q), .q_comp(qc), .carry_out(c), .zero_out(z));
  univ_reg #(.WIDTH(16), .RESET_VAL(16'hA5A5)) dut16 (.clk_in(clk), .rst_n_in(rst_n),
                .en_in(en2), .mode_in(mode2), .d_in(d2), .ser_in(ser2), .q_out(q2),
                .q_comp(qc2), .carry_out(c2), .zero_out(z2));

  always @(posedge clk)
    if ((en === 1'b1 && $isunknown(mode)) || (en2 === 1'b1 && $isunknown(mode2))) begin
      errors++;
      $display("FAIL mode_x: unknown mode on enabled edge mode=%b mode2=%b", mode, mode2);
    end

  // Reference: each mode expressed as integer arithmetic on the register value.
  function automatic void ref_op(input int w, input int q0, input int c0, input int m,
                                 input int dv, input int s, output int nq, output int nc);
    int h, full;
    h = 1 << (w - 1);
    full = 2 * h;
    nq = q0;
    nc = c0;
    case (m)
      1: begin nq = dv; nc = 0; end
      2: begin nq = (q0 * 2 + s) % full; nc = q0 / h; end
      3: begin nq = q0 / 2 + s * h; nc = q0 % 2; end
      4: begin nq = (q0 * 2) % full + q0 / h; nc = q0 / h; end
      5: begin nq = q0 / 2 + (q0 % 2) * h; nc = q0 % 2; end
      6: if (CNT) begin nq = (q0 + 1) % full; nc = (q0 == full - 1) ? 1 : 0; end
      7: if (CNT) begin nq = (q0 + full - 1) % full; nc = (q0 == 0) ? 1 : 0; end
      default: ;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic step8(input bit e, input int m, input int dv, input int s);
    en = e;
    mode = 3'(m);
    d = 8'(dv);
    ser = 1'(s);
    if (e) ref_op(8, mq, mc, m, dv, s, mq, mc);
    tick;
    en = 1'b0;
  endtask

  task automatic step16(input int m, input int dv, input int s);
    en2 = 1'b1;
    mode2 = 3'(m);
    d2 = 16'(dv);
    ser2 = 1'(s);
    tick;
    en2 = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12 rst_n = 1'b1;
    tick;
    checks++;
    if (q !== 8'h00 || c !== 1'b0 || z !== 1'b1 || qc !== 8'hFF) begin
      errors++;
      $display("FAIL reset_state q=%h c=%b z=%b qc=%h exp 00 0 1 ff", q, c, z, qc);
    end
    step8(1, 1, 'h5A, 0);
    checks++;
    if (q !== 8'h5A) begin errors++; $display("FAIL load_5a q=%h exp 5a", q); end
    en = 1'b1; mode = 3'b010; ser = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (q !== 8'h00 || c !== 1'b0 || z !== 1'b1 || qc !== 8'hFF) begin
      errors++;
      $display("FAIL async_reset q=%h c=%b z=%b qc=%h exp 00 0 1 ff", q, c, z, qc);
    end
    en = 1'b1; mode = 3'b001; d = 8'h33;
    repeat (3) tick;
    checks++;
    if (q !== 8'h00 || c !== 1'b0) begin
      errors++;
      $display("FAIL reset_ignores_edges q=%h c=%b exp 00 0", q, c);
    end
    en = 1'b0;
    rst_n = 1'b1;
    mq = 0; mc = 0;
    step8(1, 3, 0, 1);
    checks++;
    if (q !== 8'h80 || c !== 1'b0) begin
      errors++;
      $display("FAIL first_edge_after_reset q=%h c=%b exp 80 0", q, c);
    end
  endtask

  task automatic test_shift;
    step8(1, 1, 'h81, 0);
    step8(1, 2, 0, 0);
    checks++;
    if (q !== 8'h02 || c !== 1'b1) begin errors++; $display("FAIL shl q=%h c=%b exp 02 1", q, c); end
    step8(1, 3, 0, 1);
    checks++;
    if (q !== 8'h81 || c !== 1'b0) begin errors++; $display("FAIL shr q=%h c=%b exp 81 0", q, c); end
  endtask

  task automatic test_rotate;
    step8(1, 1, 'h81, 0);
    step8(1, 5, 0, 0);
    checks++;
    if (q !== 8'hC0 || c !== 1'b1) begin errors++; $display("FAIL rotr q=%h c=%b exp c0 1", q, c); end
    step8(1, 4, 0, 0);
    checks++;
    if (q !== 8'h81 || c !== 1'b1) begin errors++; $display("FAIL rotl q=%h c=%b exp 81 1", q, c); end
  endtask

  task automatic test_count;
    step8(1, 1, 'hFF, 0);
    step8(1, 6, 0, 0);
    checks++;
    if (q !== (CNT ? 8'h00 : 8'hFF) || c !== CNT || z !== CNT) begin
      errors++;
      $display("FAIL inc_wrap q=%h c=%b z=%b cnt=%b", q, c, z, CNT);
    end
    step8(1, 7, 0, 0);
    checks++;
    if (q !== 8'hFF || c !== CNT) begin
      errors++;
      $display("FAIL dec_wrap q=%h c=%b exp ff %b", q, c, CNT);
    end
    step8(1, 7, 0, 0);
    checks++;
    if (q !== (CNT ? 8'hFE : 8'hFF) || c !== 1'b0) begin
      errors++;
      $display("FAIL dec q=%h c=%b cnt=%b", q, c, CNT);
    end
  endtask

  task automatic test_enable;
    logic [7:0] v;
    step8(1, 1, 'h3C, 0);
    for (int i = 0; i < 5; i++) begin
      step8(0, 1, 'hA0 + i, i % 2);
      checks++;
      if (q !== 8'h3C) begin errors++; $display("FAIL en_low_hold i=%0d q=%h exp 3c", i, q); end
    end
    v = 8'($urandom);
    en = 1'b1; mode = 3'b001; d = ~v;
    #2;
    checks++;
    if (q !== 8'h3C) begin errors++; $display("FAIL not_transparent q=%h exp 3c", q); end
    d = v;
    mq = int'(v); mc = 0;
    tick;
    en = 1'b0; d = ~v;
    checks++;
    if (q !== v) begin errors++; $display("FAIL en_sixth_edge q=%h exp %h", q, v); end
    tick;
    checks++;
    if (q !== v) begin errors++; $display("FAIL hold_after_load q=%h exp %h", q, v); end
  endtask

  task automatic test_random;
    step8(1, 1, int'($urandom_range(0, 255)), 0);
    for (int i = 0; i < 400; i++) begin
      step8(($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
      checks++;
      if (q !== 8'(mq) || c !== 1'(mc) || z !== (mq == 0) || qc !== ~8'(mq)) begin
        errors++;
        $display("FAIL random i=%0d q=%h c=%b z=%b qc=%h exp q=%h c=%0d", i, q, c, z, qc, 8'(mq), mc);
      end
    end
  endtask

  task automatic test_wide;
    int wq, wc;
    rst_n = 1'b0;
    #1;
    checks++;
    if (q2 !== 16'hA5A5 || c2 !== 1'b0 || qc2 !== 16'h5A5A || z2 !== 1'b0) begin
      errors++;
      $display("FAIL wide_reset q=%h c=%b qc=%h z=%b exp a5a5 0 5a5a 0", q2, c2, qc2, z2);
    end
    #1 rst_n = 1'b1;
    step16(1, 'h8001, 0);
    step16(2, 0, 0);
    checks++;
    if (q2 !== 16'h0002 || c2 !== 1'b1) begin errors++; $display("FAIL wide_shl q=%h c=%b exp 0002 1", q2, c2); end
    step16(3, 0, 1);
    checks++;
    if (q2 !== 16'h8001 || c2 !== 1'b0) begin errors++; $display("FAIL wide_shr q=%h c=%b exp 8001 0", q2, c2); end
    wq = 'h8001; wc = 0;
    for (int i = 0; i < 100; i++) begin
      int m, dv, s;
      m = int'($urandom_range(0, 7));
      dv = int'($urandom_range(0, 65535));
      s = int'($urandom_range(0, 1));
      ref_op(16, wq, wc, m, dv, s, wq, wc);
      step16(m, dv, s);
      checks++;
      if (q2 !== 16'(wq) || c2 !== 1'(wc)) begin
        errors++;
        $display("FAIL wide_random i=%0d q=%h c=%b exp %h %0d", i, q2, c2, 16'(wq), wc);
      end
    end
  endtask

  initial begin
    en = 1'b0; mode = 3'b000; d = '0; ser = 1'b0;
    en2 = 1'b0; mode2 = 3'b000; d2 = '0; ser2 = 1'b0;
    test_reset;
    test_shift;
    test_rotate;
    test_count;
    test_enable;
    test_random;
    test_wide;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/univ_reg.md
UNIV_REG -- requirements
Module: univ_reg

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits, legal range 2..64.
REQ-002 Parameter RESET_VAL, default 0: value q_out takes on reset, WIDTH bits.
REQ-003 clk_in  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-005 en_in  input  1  update enable; 0 holds all state regardless of mode_in.
REQ-006 mode_in  input  3  operation select, encodings per REQ-011.
REQ-007 d_in  input  WIDTH  parallel load data.
REQ-008 ser_in  input  1  serial fill bit for shift modes.
REQ-009 q_out  output  WIDTH  registered value; q_comp  output  WIDTH  bitwise inverse of q_out.
REQ-010 carry_out  output  1  registered shifted-out, rotated, carry or borrow bit; zero_out  output  1  high when q_out == 0.

Function
REQ-011 Modes: 000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROTL, 101 ROTR, 110 INC, 111 DEC.
REQ-012 All operations act on the edge where en_in=1; results are visible on q_out one cycle later.
REQ-013 HOLD: q_out and carry_out unchanged.
REQ-014 LOAD: q_out <= d_in, carry_out <= 0.
REQ-015 SHL: q_out <= {q[WIDTH-2:0], ser_in}, carry_out <= old q[WIDTH-1].
REQ-016 SHR: q_out <= {ser_in, q[WIDTH-1:1]}, carry_out <= old q[0].
REQ-017 ROTL: q_out <= {q[WIDTH-2:0], q[WIDTH-1]}, carry_out <= old q[WIDTH-1]; ser_in ignored.
REQ-018 ROTR: q_out <= {q[0], q[WIDTH-1:1]}, carry_out <= old q[0]; ser_in ignored.
REQ-019 INC: q_out <= q+1 modulo 2^WIDTH; carry_out <= 1 only when old q is all ones (wrap to 0), else 0.
REQ-020 DEC: q_out <= q-1 modulo 2^WIDTH; carry_out <= 1 only when old q is 0 (wrap to all ones), else 0.
REQ-021 en_in=0: q_out and carry_out hold for any mode_in, d_in or ser_in value.
REQ-022 q_comp and zero_out are combinational from q_out, with no added latency and no glitch dependence on inputs.
REQ-023 mode_in and d_in changing between edges have no effect on q_out (edge-triggered, never transparent).
REQ-024 Mode X/Z on an enabled edge is an error; the bench flags it, and the RTL is not required to hold.

Reset
REQ-025 rst_n_in=0 asynchronously forces q_out=RESET_VAL and carry_out=0 without waiting for clk_in.
REQ-026 While rst_n_in=0, all edges are ignored, including those with en_in=1.
REQ-027 Reset asserted mid-operation discards the in-flight update; no partial result is retained.
REQ-028 The first enabled edge after rst_n_in rises operates on RESET_VAL.

Configuration
REQ-029 Macro UNIV_REG_COUNT_EN defined: INC and DEC behave per REQ-019/REQ-020.
REQ-030 Macro UNIV_REG_COUNT_EN undefined: no adder or subtractor is built, and encodings 110/111 behave exactly as HOLD (q_out and carry_out unchanged).

Verification (WIDTH=8, RESET_VAL=0 unless stated)
REQ-031 Drive rst_n_in=0 between clock edges with q_out=8'h5A -> q_out=8'h00, carry_out=0, zero_out=1, and q_comp=8'hFF immediately; edges with en_in=1 during reset change nothing.
REQ-032 Load 8'h81, then SHL with ser_in=0 -> q_out=8'h02, carry_out=1; then SHR with ser_in=1 -> q_out=8'h81, carry_out=0.
REQ-033 Load 8'h81, then ROTR -> q_out=8'hC0, carry_out=1; then ROTL -> q_out=8'h81, carry_out=1.
REQ-034 With UNIV_REG_COUNT_EN defined: load 8'hFF, INC -> q_out=8'h00, carry_out=1, zero_out=1; DEC -> q_out=8'hFF, carry_out=1; DEC -> q_out=8'hFE, carry_out=0. Without the macro, the same stimulus leaves q_out=8'hFF and carry_out=0.
REQ-035 en_in=0 with mode_in=LOAD and d_in toggling for 5 cycles -> q_out unchanged; en_in=1 on the 6th edge -> q_out equals d_in at that edge only.
REQ-036 Repeat REQ-032 with WIDTH=16 and RESET_VAL=16'hA5A5 -> after reset q_out=16'hA5A5; load 16'h8001, SHL with ser_in=0 -> q_out=16'h0002, carry_out=1.
